// File: rtl/wbc_arbiter_wdog.sv
// Round-robin WISHBONE control-bus arbiter with a stall watchdog.
// Grants one master at a time and aborts strobes that never get a slave response.
//
// Ports:
//   clk_i         bus clock
//   rst_i         synchronous active-high reset
//   cyc_i         per-master cycle request
//   stb_i         strobe of the granted master (muxed by intercon)
//   ack_i/err_i/rty_i  muxed slave response
//   gnt_o         registered one-hot grant, or all-zero
//   tmo_err_o     one-cycle injected error towards the owner
//   tmo_count_o   saturating count of watchdog aborts
//   tmo_master_o  index of the master in the most recent abort
//   busy_o        high while any grant is held
module wbc_arbiter_wdog #(
    parameter int NUM_MASTERS = 3,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_WIDTH   = 16,
    parameter int IDX_WIDTH   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic                   stb_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   tmo_err_o,
    output logic [CNT_WIDTH-1:0]   tmo_count_o,
    output logic [IDX_WIDTH-1:0]   tmo_master_o,
    output logic                   busy_o
);

    // Stall counter only has to reach TIMEOUT-1.
    localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STALL_LAST =
        SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX =
        IDX_WIDTH'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN,
        S_ABORT
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0]   owner_q, owner_d;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]          stall_q, stall_d;
    logic [CNT_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [IDX_WIDTH-1:0]   tmo_mst_q, tmo_mst_d;
    logic                   tmo_err;

    // ------------------------------------------------------------
    // Round-robin pick: lowest request at or above ptr, else the
    // lowest request overall (wrap-around).
    // ------------------------------------------------------------
    logic [NUM_MASTERS-1:0] hi_mask;
    logic [NUM_MASTERS-1:0] req_hi;
    logic [NUM_MASTERS-1:0] pick_src;
    logic [NUM_MASTERS-1:0] pick_oh;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [IDX_WIDTH-1:0][NUM_MASTERS-1:0] enc_mask;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_hi
        assign hi_mask[i] = (IDX_WIDTH'(i) >= ptr_q);
    end

    // enc_mask[b] selects every master whose index has bit b set,
    // turning the one-hot pick into a binary index with plain ORs.
    for (genvar b = 0; b < IDX_WIDTH; b++) begin : g_enc
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_bit
            assign enc_mask[b][i] = (((i >> b) & 1) != 0);
        end
        assign pick_idx[b] = |(pick_oh & enc_mask[b]);
    end

    assign req_hi   = cyc_i & hi_mask;
    assign pick_src = (|req_hi) ? req_hi : cyc_i;
    // Isolate the lowest set bit.
    assign pick_oh  = pick_src & (~pick_src + NUM_MASTERS'(1));

    // ------------------------------------------------------------
    // Owner status
    // ------------------------------------------------------------
    logic                 own_cyc;
    logic                 resp;
    logic                 stall;
    logic [IDX_WIDTH-1:0] ptr_next;

    assign own_cyc  = |(cyc_i & gnt_q);
    assign resp     = ack_i | err_i | rty_i;
    assign stall    = stb_i & ~resp;
    assign ptr_next = (owner_q == LAST_IDX) ? '0
                    : owner_q + IDX_WIDTH'(1);

    // ------------------------------------------------------------
    // State register
    // ------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            stall_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_mst_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            stall_q   <= stall_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_mst_q <= tmo_mst_d;
        end
    end

    // ------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        stall_d   = stall_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_mst_d = tmo_mst_q;
        tmo_err   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                stall_d = '0;
                if (|cyc_i) begin
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    state_d = S_OWN;
                end
            end

            S_OWN: begin
                if (!own_cyc) begin
                    // Release; the dead cycle in IDLE separates owners.
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    stall_d = '0;
                    state_d = S_IDLE;
                end else if (stall) begin
                    if (WDOG_EN && stall_q == STALL_LAST) begin
                        stall_d = '0;
                        state_d = S_ABORT;
                    end else if (WDOG_EN) begin
                        stall_d = stall_q + SW'(1);
                    end
                end else begin
                    stall_d = '0;
                end
            end

            S_ABORT: begin
                stall_d = '0;
                if (!own_cyc) begin
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OWN;
                    // A late slave answer wins over the abort.
                    if (!resp) begin
                        tmo_err   = 1'b1;
                        tmo_mst_d = owner_q;
                        if (tmo_cnt_q != '1) begin
                            tmo_cnt_d = tmo_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
            end

            default: begin
                gnt_d   = '0;
                stall_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    assign gnt_o        = gnt_q;
    assign busy_o       = |gnt_q;
    assign tmo_err_o    = tmo_err & ~rst_i;
    assign tmo_count_o  = tmo_cnt_q;
    assign tmo_master_o = tmo_mst_q;

endmodule
